// File: rtl/data_port_responder.sv
// Purpose: word-addressed 32-bit data port responder with byte-enable writes and range checking.
// Latency: data_resp pulses exactly LATENCY cycles after a request is first seen in IDLE.
// Backpressure: one transaction at a time; requests are only sampled in IDLE, so the initiator holds them until data_resp.
module data_port_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mbe,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_resp,
    output logic [31:0] data_rdata,
    output logic        addr_err
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    wr_q;
    logic [3:0]              mbe_q;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic                    resp_q;
    logic [31:0]             rdata_q;
    logic                    err_q;

    // Storage is deliberately not reset: contents survive rst and start undefined.
    logic [31:0]             mem_q [DEPTH];

    logic                    req;
    logic [31:0]             eff_addr;
    logic                    eff_wr;
    logic                    in_range;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    enter_resp;
    logic [31:0]             rdata_d;

    // Decode the request being serviced: live inputs while IDLE (needed when
    // LATENCY==1, since acceptance and entry to RESP share one edge), latched copy otherwise.
    always_comb begin
        req        = data_read | data_write;
        eff_addr   = (state_q == IDLE) ? data_addr  : addr_q;
        eff_wr     = (state_q == IDLE) ? data_write : wr_q;
        in_range   = ((eff_addr >> (ADDR_WIDTH + 2)) == 32'd0);
        idx        = eff_addr[ADDR_WIDTH+1:2];
        enter_resp = ((state_q == IDLE) && req && (LATENCY == 1)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd1));
        rdata_d    = in_range ? mem_q[idx] : 32'd0;
    end

    // Transaction FSM with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            mbe_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            resp_q  <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            resp_q <= enter_resp;
            err_q  <= enter_resp && !in_range;
            // Read data only changes when a read enters RESP; writes leave it alone.
            if (enter_resp && !eff_wr) begin
                rdata_q <= rdata_d;
            end
            case (state_q)
                IDLE: begin
                    if (req) begin
                        wr_q    <= data_write;
                        mbe_q   <= data_mbe;
                        addr_q  <= data_addr;
                        wdata_q <= data_wdata;
                        cnt_q   <= CNT_INIT;
                        state_q <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Byte-masked write commits on the edge that ends RESP; out-of-range writes
    // and transactions cut short by rst never touch the array.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == RESP) && wr_q && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (mbe_q[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign data_resp  = resp_q;
    assign data_rdata = rdata_q;
    assign addr_err   = err_q;

endmodule

// File: tb/tb_data_port_responder.sv
module tb_data_port_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // LATENCY=3 instance
    logic        a_read, a_write;
    logic [3:0]  a_mbe;
    logic [31:0] a_addr, a_wdata;
    logic        a_resp, a_err;
    logic [31:0] a_rdata;

    // LATENCY=1 instance
    logic        b_read, b_write;
    logic [3:0]  b_mbe;
    logic [31:0] b_addr, b_wdata;
    logic        b_resp, b_err;
    logic [31:0] b_rdata;

    int n_vec = 0;
    int n_err = 0;

    data_port_responder #(.ADDR_WIDTH(8), .LATENCY(3)) u3 (
        .clk        (clk),
        .rst        (rst),
        .data_read  (a_read),
        .data_write (a_write),
        .data_mbe   (a_mbe),
        .data_addr  (a_addr),
        .data_wdata (a_wdata),
        .data_resp  (a_resp),
        .data_rdata (a_rdata),
        .addr_err   (a_err)
    );

    data_port_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u1 (
        .clk        (clk),
        .rst        (rst),
        .data_read  (b_read),
        .data_write (b_write),
        .data_mbe   (b_mbe),
        .data_addr  (b_addr),
        .data_wdata (b_wdata),
        .data_resp  (b_resp),
        .data_rdata (b_rdata),
        .addr_err   (b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic a_idle();
        a_read  = 1'b0;
        a_write = 1'b0;
        a_addr  = 32'hFFFF_FFFF;
        a_wdata = 32'h0;
        a_mbe   = 4'h0;
    endtask

    // One transaction on the LATENCY=3 port. Response must appear only in
    // cycle T+3; inputs are dropped at the negedge of cycle T+drop_k.
    task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mbe, input int drop_k,
                        input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err);
        @(posedge clk); #1;
        a_read  = 1'b1;
        a_write = wr;
        a_addr  = addr;
        a_wdata = wdata;
        a_mbe   = mbe;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            chk({tag, " resp"}, 32'(a_resp), 32'(k == 3));
            if (k == drop_k) a_idle();
        end
        if (chk_rd) chk({tag, " rdata"}, a_rdata, exp_rd);
        chk({tag, " addr_err"}, 32'(a_err), 32'(exp_err));
        a_idle();
    endtask

    initial begin
        rst = 1'b1;
        a_idle();
        b_read = 1'b0; b_write = 1'b0; b_mbe = 4'h0; b_addr = 32'h0; b_wdata = 32'h0;

        // Reset state
        #12;
        chk("rst resp3",  32'(a_resp), 32'h0);
        chk("rst rdata3", a_rdata,     32'h0);
        chk("rst err3",   32'(a_err),  32'h0);
        chk("rst resp1",  32'(b_resp), 32'h0);
        chk("rst rdata1", b_rdata,     32'h0);
        chk("rst err1",   32'(b_err),  32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Full write then read-back
        xact("wr10",  1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3, 1'b0, 32'h0, 1'b0);
        xact("rd10",  1'b0, 32'h10, 32'h0,        4'h0, 3, 1'b1, 32'hDEADBEEF, 1'b0);
        // Partial write (bytes 0 and 2)
        xact("pwr10", 1'b1, 32'h10, 32'h11223344, 4'b0101, 3, 1'b0, 32'h0, 1'b0);
        xact("prd10", 1'b0, 32'h10, 32'h0,        4'h0, 3, 1'b1, 32'hDE22BE44, 1'b0);
        // mbe==0 write changes nothing
        xact("zwr10", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 3, 1'b0, 32'h0, 1'b0);
        xact("zrd10", 1'b0, 32'h10, 32'h0,        4'h0, 3, 1'b1, 32'hDE22BE44, 1'b0);
        // Out of range: 0x400 would alias word 0 if the range check were missing
        xact("wr00",  1'b1, 32'h0,   32'h0BADF00D, 4'hF, 3, 1'b0, 32'h0, 1'b0);
        xact("wroor", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 3, 1'b0, 32'h0, 1'b1);
        xact("rdoor", 1'b0, 32'h400, 32'h0,        4'h0, 3, 1'b1, 32'h0, 1'b1);
        xact("rd00",  1'b0, 32'h0,   32'h0,        4'h0, 3, 1'b1, 32'h0BADF00D, 1'b0);
        xact("rdhi",  1'b0, 32'h8000_0010, 32'h0,  4'h0, 3, 1'b1, 32'h0, 1'b1);
        // Request dropped one cycle after acceptance
        xact("drrd",  1'b0, 32'h10, 32'h0,        4'h0, 1, 1'b1, 32'hDE22BE44, 1'b0);
        xact("drwr",  1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 1, 1'b0, 32'h0, 1'b0);
        xact("rd24",  1'b0, 32'h24, 32'h0,        4'h0, 3, 1'b1, 32'hCAFEF00D, 1'b0);

        // Reset during WAIT aborts a write
        xact("wr20",  1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 3, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        a_read = 1'b1; a_write = 1'b1; a_addr = 32'h20; a_wdata = 32'h55; a_mbe = 4'hF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        a_idle();
        #1;
        chk("rstw resp",  32'(a_resp), 32'h0);
        chk("rstw rdata", a_rdata,     32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rstw noresp", 32'(a_resp), 32'h0);
        end
        xact("rd20a", 1'b0, 32'h20, 32'h0, 4'h0, 3, 1'b1, 32'hA5A5A5A5, 1'b0);

        // Reset during RESP: response killed and no array write
        @(posedge clk); #1;
        a_read = 1'b0; a_write = 1'b1; a_addr = 32'h20; a_wdata = 32'h77777777; a_mbe = 4'hF;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            chk("rstr resp", 32'(a_resp), 32'(k == 3));
        end
        rst = 1'b1;
        a_idle();
        #1;
        chk("rstr kill", 32'(a_resp), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        xact("rd20b", 1'b0, 32'h20, 32'h0, 4'h0, 3, 1'b1, 32'hA5A5A5A5, 1'b0);

        // LATENCY=1: read+write together performs a write
        @(posedge clk); #1;
        b_read = 1'b1; b_write = 1'b1; b_addr = 32'h4; b_wdata = 32'h12345678; b_mbe = 4'hF;
        @(negedge clk);
        chk("l1 wr resp0", 32'(b_resp), 32'h0);
        @(negedge clk);
        chk("l1 wr resp1", 32'(b_resp), 32'h1);
        b_read = 1'b0; b_write = 1'b0; b_mbe = 4'h0;
        // Held read: response every second cycle
        @(posedge clk); #1;
        b_read = 1'b1; b_addr = 32'h4;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("l1 rd resp", 32'(b_resp), 32'(k % 2));
            if (k % 2 == 1) chk("l1 rd rdata", b_rdata, 32'h12345678);
        end
        b_read = 1'b0;
        @(negedge clk);
        chk("l1 idle resp", 32'(b_resp), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
